mips_mc_controller: RTL and testbench
=====================================

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 Parameters: none; encodings are fixed by the shared package.
REQ-002 clk  in  1  rising-edge clock; the only clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  IR[31:26], sampled in ID.
REQ-005 funct  in  6  IR[5:0], sampled in ID and EX.
REQ-006 ALUzero  in  1  datapath ALU zero flag.
REQ-007 PCWrite, PCWriteCond, IorD, IRWrite  out  1 each  PC/IR/address-source strobes.
REQ-008 MemRead, MemWrite, MemToReg, RegDst, RegWrite, Jal, slt  out  1 each  datapath controls.
REQ-009 ALUsrcA  out  1  0=PC, 1=rs.
REQ-010 ALUsrcB  out  2  00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2.
REQ-011 ALU_OP  out  3  000 AND, 001 OR, 010 ADD, 110 SUB.
REQ-012 PCsrc  out  2  00 ALUOut (branch target), 01 ALU result (PC+4), 10 jump target, 11 rs.
REQ-013 done  out  1  one-cycle pulse in the final state of each instruction.
REQ-014 err  out  1  illegal opcode/funct seen; sticky until reset.

Function
REQ-015 Moore FSM; all outputs are decoded from the state register only, except PCWrite/PCWriteCond, which are already decoded per state (the datapath ANDs PCWriteCond with ALUzero).
REQ-016 States: IF, ID, MEMADR, LW_MEM, LW_WB, SW_MEM, R_EX, R_WB, I_EX, I_WB, BEQ, J, JAL, JR, ERR.
REQ-017 IF: IorD=0, MemRead=1, IRWrite=1, ALUsrcA=0, ALUsrcB=01, ALU_OP=ADD, PCsrc=01, PCWrite=1; next state ID.
REQ-018 ID: ALUsrcA=0, ALUsrcB=11, ALU_OP=ADD (computes branch target into ALUOut); next state decoded from opcode.
REQ-019 ID decode: lw/sw (100011/101011) -> MEMADR; R-type (000000) with funct 001000 -> JR; any other legal R-type -> R_EX; addi/slti (001000/001010) -> I_EX; beq (000100) -> BEQ; j (000010) -> J; jal (000011) -> JAL; anything else -> ERR.
REQ-020 MEMADR: ALUsrcA=1, ALUsrcB=10, ADD; next LW_MEM (lw) or SW_MEM (sw).
REQ-021 LW_MEM: IorD=1, MemRead=1 -> LW_WB; LW_WB: RegDst=0, MemToReg=1, RegWrite=1, done=1 -> IF.
REQ-022 SW_MEM: IorD=1, MemWrite=1, done=1 -> IF.
REQ-023 R_EX: ALUsrcA=1, ALUsrcB=00; ALU_OP from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SUB; -> R_WB. An illegal funct goes to ERR from ID.
REQ-024 R_WB: RegDst=1, RegWrite=1, MemToReg=0, slt=1 only when funct=101010, ALU_OP held as in R_EX, done=1 -> IF.
REQ-025 I_EX: ALUsrcA=1, ALUsrcB=10, ADD for addi, SUB for slti -> I_WB; I_WB: RegDst=0, RegWrite=1, slt=(slti), done=1 -> IF.
REQ-026 BEQ: ALUsrcA=1, ALUsrcB=00, SUB, PCsrc=00, PCWriteCond=1, done=1 -> IF.
REQ-027 J: PCsrc=10, PCWrite=1, done=1 -> IF. JAL: as J, plus Jal=1, RegWrite=1 (r31 <= PC+4). JR: PCsrc=11, PCWrite=1, done=1 -> IF.
REQ-028 ERR: all strobes 0, err=1; remains in ERR until rst.
REQ-029 Latency: lw 5 cycles; R/I-type 4 cycles; sw 4 cycles; beq/j/jal/jr 3 cycles.
REQ-030 Any output not listed for a state is 0; no write strobe is asserted in two consecutive states except PCWrite.

Reset
REQ-031 rst asserted at any time, including mid-instruction, forces state=IF and err=0 immediately; all outputs take the IF decode.
REQ-032 On the first rising edge after rst deasserts, IF's strobes take effect.

Structure
REQ-033 State encoding, opcode/funct constants, ALU_OP, ALUsrcB and PCsrc codes belong in a shared package (mips_pkg) also used by the datapath.
REQ-034 One sub-module: mips_alu_decoder (funct + class -> ALU_OP, slt), combinational.

Verification
REQ-035 rst mid-LW_MEM -> next cycle state IF, MemWrite=0, RegWrite=0, err=0.
REQ-036 opcode=100011 -> states IF,ID,MEMADR,LW_MEM,LW_WB; done only in cycle 5, with MemToReg=1 and RegWrite=1.
REQ-037 R-type funct=101010 -> R_EX ALU_OP=110; R_WB slt=1, RegDst=1, done=1.
REQ-038 beq: ALUzero=1 and then ALUzero=0 -> PCWriteCond=1, PCsrc=00 in cycle 3 in both cases; PCWrite=0.
REQ-039 jal -> cycle 3: Jal=1, RegWrite=1, PCsrc=10, PCWrite=1.
REQ-040 opcode=111111 -> ERR, err=1 held for 10 cycles with all strobes 0; rst clears it.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the multi-cycle MIPS controller and its datapath:
// controller state encoding, opcode/funct constants, ALU_OP, ALUsrcB and
// PCsrc select codes, and the ALU operation class used by the ALU decoder.
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        S_IF,
        S_ID,
        S_MEMADR,
        S_LW_MEM,
        S_LW_WB,
        S_SW_MEM,
        S_R_EX,
        S_R_WB,
        S_I_EX,
        S_I_WB,
        S_BEQ,
        S_J,
        S_JAL,
        S_JR,
        S_ERR
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    // ALU_OP codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // ALUsrcB codes
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PCsrc codes
    localparam logic [1:0] PC_ALUOUT = 2'b00;
    localparam logic [1:0] PC_ALURES = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // What the controller asks of the ALU decoder in a given state.
    typedef enum logic [1:0] {
        ALU_CLS_NONE,   // ALU unused: ALU_OP = 000
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT   // R-type: operation chosen by funct
    } alu_cls_t;

    // R-type funct values that execute through R_EX/R_WB (jr is handled apart).
    function automatic logic is_alu_funct(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// -----------------------------------------------------------------------------
// mips_alu_decoder
// Combinational ALU control: turns the controller's ALU class plus the
// instruction funct field into an ALU_OP code and a set-less-than flag.
//   cls_i     in  ALU operation class requested by the current state
//   funct_i   in  6-bit R-type funct field
//   alu_op_o  out ALU_OP code (AND/OR/ADD/SUB)
//   slt_o     out high when the R-type operation is slt
// -----------------------------------------------------------------------------
module mips_alu_decoder
    import mips_pkg::*;
(
    input  alu_cls_t   cls_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       slt_o
);

    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        alu_op_o = ALU_AND;
        slt_o    = 1'b0;
        case (cls_i)
            ALU_CLS_ADD: alu_op_o = ALU_ADD;
            ALU_CLS_SUB: alu_op_o = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct_i)
                    F_ADD: alu_op_o = ALU_ADD;
                    F_SUB: alu_op_o = ALU_SUB;
                    F_AND: alu_op_o = ALU_AND;
                    F_OR:  alu_op_o = ALU_OR;
                    F_SLT: begin
                        // slt is a subtract whose sign the datapath keeps
                        alu_op_o = ALU_SUB;
                        slt_o    = 1'b1;
                    end
                    default: alu_op_o = ALU_AND;
                endcase
            end
            default: alu_op_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
// Moore control FSM for a multi-cycle MIPS subset (lw, sw, add, sub, and, or,
// slt, addi, slti, beq, j, jal, jr). Outputs depend only on the state register
// and the instruction fields captured during ID.
//   clk, rst                    clock, asynchronous active-high reset
//   opcode, funct               instruction fields, sampled in ID
//   ALUzero                     ALU zero flag (consumed by the datapath)
//   PCWrite, PCWriteCond        PC update strobes (datapath ANDs PCWriteCond
//                               with ALUzero)
//   IorD, IRWrite               memory address source, IR load
//   MemRead, MemWrite           memory strobes
//   MemToReg, RegDst, RegWrite  register-file write controls
//   Jal, slt                    r31 link write, set-less-than result select
//   ALUsrcA, ALUsrcB, ALU_OP    ALU operand selects and operation
//   PCsrc                       next-PC source
//   done                        pulse in the last state of each instruction
//   err                         illegal instruction seen; held until reset
// -----------------------------------------------------------------------------
module mips_mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ALUzero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       Jal,
    output logic       slt,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [2:0] ALU_OP,
    output logic [1:0] PCsrc,
    output logic       done,
    output logic       err
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;

    alu_cls_t   alu_cls;
    logic [2:0] dec_alu_op;
    logic       dec_slt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IF;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
        end
    end

    // Instruction fields are captured during ID so later states decode from
    // registers rather than from the live IR bus.
    always_comb begin
        opcode_d = opcode_q;
        funct_d  = funct_q;
        if (state_q == S_ID) begin
            opcode_d = opcode;
            funct_d  = funct;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == F_JR)           state_d = S_JR;
                        else if (is_alu_funct(funct)) state_d = S_R_EX;
                        else                         state_d = S_ERR;
                    end
                    OP_ADDI, OP_SLTI: state_d = S_I_EX;
                    OP_BEQ:           state_d = S_BEQ;
                    OP_J:             state_d = S_J;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_ERR;
                endcase
            end
            S_MEMADR: state_d = (opcode_q == OP_LW) ? S_LW_MEM : S_SW_MEM;
            S_LW_MEM: state_d = S_LW_WB;
            S_R_EX:   state_d = S_R_WB;
            S_I_EX:   state_d = S_I_WB;
            S_LW_WB, S_SW_MEM, S_R_WB, S_I_WB,
            S_BEQ, S_J, S_JAL, S_JR: state_d = S_IF;
            S_ERR:    state_d = S_ERR;   // only rst leaves ERR
            default:  state_d = S_IF;    // unused encoding
        endcase
    end

    // Output decode
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        Jal         = 1'b0;
        slt         = 1'b0;
        ALUsrcA     = 1'b0;
        ALUsrcB     = SRCB_RT;
        PCsrc       = PC_ALUOUT;
        done        = 1'b0;
        err         = 1'b0;
        alu_cls     = ALU_CLS_NONE;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUsrcB = SRCB_FOUR;
                alu_cls = ALU_CLS_ADD;
                PCsrc   = PC_ALURES;
                PCWrite = 1'b1;
            end
            S_ID: begin
                ALUsrcB = SRCB_IMM_SH2;   // branch target into ALUOut
                alu_cls = ALU_CLS_ADD;
            end
            S_MEMADR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
                alu_cls = ALU_CLS_ADD;
            end
            S_LW_MEM: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_LW_WB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                done     = 1'b1;
            end
            S_SW_MEM: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                done     = 1'b1;
            end
            S_R_EX: begin
                ALUsrcA = 1'b1;
                alu_cls = ALU_CLS_FUNCT;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                alu_cls  = ALU_CLS_FUNCT;   // keep ALU_OP stable through write-back
                slt      = dec_slt;
                done     = 1'b1;
            end
            S_I_EX: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
                alu_cls = (opcode_q == OP_SLTI) ? ALU_CLS_SUB : ALU_CLS_ADD;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                slt      = (opcode_q == OP_SLTI);
                done     = 1'b1;
            end
            S_BEQ: begin
                ALUsrcA     = 1'b1;
                alu_cls     = ALU_CLS_SUB;
                PCsrc       = PC_ALUOUT;
                PCWriteCond = 1'b1;
                done        = 1'b1;
            end
            S_J: begin
                PCsrc   = PC_JUMP;
                PCWrite = 1'b1;
                done    = 1'b1;
            end
            S_JAL: begin
                PCsrc    = PC_JUMP;
                PCWrite  = 1'b1;
                Jal      = 1'b1;
                RegWrite = 1'b1;   // r31 <= PC+4
                done     = 1'b1;
            end
            S_JR: begin
                PCsrc   = PC_RS;
                PCWrite = 1'b1;
                done    = 1'b1;
            end
            S_ERR: err = 1'b1;
            default: ;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .cls_i    (alu_cls),
        .funct_i  (funct_q),
        .alu_op_o (dec_alu_op),
        .slt_o    (dec_slt)
    );

    assign ALU_OP = dec_alu_op;

endmodule

// File: tb/tb_mips_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_controller
// Self-checking bench for mips_mc_controller. Each instruction in the vector
// table carries its expected per-cycle output words; these are queued when the
// instruction is driven and popped as each cycle's outputs are sampled on the
// falling clock edge. Hand-written sequences cover reset mid-instruction and
// the illegal-instruction trap.
// Output word layout (MSB first):
//   PCWrite PCWriteCond IorD IRWrite MemRead MemWrite MemToReg RegDst RegWrite
//   Jal slt ALUsrcA ALUsrcB[1:0] ALU_OP[2:0] PCsrc[1:0] done err
// -----------------------------------------------------------------------------
module tb_mips_mc_controller;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       ALUzero;
    logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic       MemToReg, RegDst, RegWrite, Jal, slt, ALUsrcA, done, err;
    logic [1:0] ALUsrcB;
    logic [2:0] ALU_OP;
    logic [1:0] PCsrc;

    mips_mc_controller dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .ALUzero     (ALUzero),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .Jal         (Jal),
        .slt         (slt),
        .ALUsrcA     (ALUsrcA),
        .ALUsrcB     (ALUsrcB),
        .ALU_OP      (ALU_OP),
        .PCsrc       (PCsrc),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                  MemToReg, RegDst, RegWrite, Jal, slt, ALUsrcA, ALUsrcB,
                  ALU_OP, PCsrc, done, err};

    typedef struct packed {
        logic [5:0]       opcode;
        logic [5:0]       funct;
        logic             zero;
        logic [2:0]       len;
        logic [4:0][20:0] exp;
    } vec_t;

    vec_t        vecs [16];
    int          nvec = 0;
    logic [20:0] sb_q [$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [20:0] wd(
        input logic pcw, pcwc, iord, irw, mr, mw, m2r, rdst, rw, jal, st, srca,
        input logic [1:0] srcb, input logic [2:0] op, input logic [1:0] pcs,
        input logic dn, er);
        return {pcw, pcwc, iord, irw, mr, mw, m2r, rdst, rw, jal, st, srca,
                srcb, op, pcs, dn, er};
    endfunction

    task automatic check(input string name, input logic [20:0] act,
                         input logic [20:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, expv);
        end
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [2:0] len,
                           input logic [20:0] e0, e1, e2, e3, e4);
        vec_t v;
        v.opcode = op;
        v.funct  = fn;
        v.zero   = z;
        v.len    = len;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        vecs[nvec] = v;
        nvec++;
    endtask

    // Called at a falling edge with the DUT in IF; returns at the falling edge
    // after the instruction's last state.
    task automatic run_vec(input int i);
        vec_t        v;
        logic [20:0] e;
        v = vecs[i];
        opcode  = v.opcode;
        funct   = v.funct;
        ALUzero = v.zero;
        for (int k = 0; k < int'(v.len); k++) sb_q.push_back(v.exp[k]);
        for (int k = 0; k < int'(v.len); k++) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL v%0d c%0d: scoreboard empty", i, k);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d op=%b fn=%b c%0d", i, v.opcode, v.funct, k),
                      obs, e);
            end
            @(negedge clk);
        end
    endtask

    logic [20:0] w_if, w_id, w_memadr, w_lwmem, w_lwwb, w_swmem;
    logic [20:0] w_iex_add, w_iex_sub, w_iwb, w_iwb_slt, w_beq;
    logic [20:0] w_j, w_jal, w_jr, w_err;

    function automatic logic [20:0] w_rex(input logic [2:0] op);
        return wd(0,0,0,0,0,0,0,0,0,0,0,1, 2'b00, op, 2'b00, 0,0);
    endfunction

    function automatic logic [20:0] w_rwb(input logic [2:0] op, input logic st);
        return wd(0,0,0,0,0,0,0,1,1,0,st,0, 2'b00, op, 2'b00, 1,0);
    endfunction

    initial begin
        //            pcw pcwc iord irw mr mw m2r rdst rw jal slt srca srcb  op      pcs  dn er
        w_if      = wd(1,0,0,1,1,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b01, 0,0);
        w_id      = wd(0,0,0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0);
        w_memadr  = wd(0,0,0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0);
        w_lwmem   = wd(0,0,1,0,1,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
        w_lwwb    = wd(0,0,0,0,0,0,1,0,1,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);
        w_swmem   = wd(0,0,1,0,0,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);
        w_iex_add = wd(0,0,0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0);
        w_iex_sub = wd(0,0,0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b110, 2'b00, 0,0);
        w_iwb     = wd(0,0,0,0,0,0,0,0,1,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);
        w_iwb_slt = wd(0,0,0,0,0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);
        w_beq     = wd(0,1,0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b00, 1,0);
        w_j       = wd(1,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,0);
        w_jal     = wd(1,0,0,0,0,0,0,0,1,1,0,0, 2'b00, 3'b000, 2'b10, 1,0);
        w_jr      = wd(1,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b11, 1,0);
        w_err     = wd(0,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,1);

        //      opcode     funct      z  len  cycle words
        add_vec(6'b100011, 6'b000000, 0, 5, w_if, w_id, w_memadr, w_lwmem, w_lwwb);   // 0 lw
        add_vec(6'b101011, 6'b000000, 0, 4, w_if, w_id, w_memadr, w_swmem, '0);       // 1 sw
        add_vec(6'b000000, 6'b100000, 0, 4, w_if, w_id, w_rex(3'b010), w_rwb(3'b010, 0), '0); // 2 add
        add_vec(6'b000000, 6'b100010, 0, 4, w_if, w_id, w_rex(3'b110), w_rwb(3'b110, 0), '0); // 3 sub
        add_vec(6'b000000, 6'b100100, 0, 4, w_if, w_id, w_rex(3'b000), w_rwb(3'b000, 0), '0); // 4 and
        add_vec(6'b000000, 6'b100101, 0, 4, w_if, w_id, w_rex(3'b001), w_rwb(3'b001, 0), '0); // 5 or
        add_vec(6'b000000, 6'b101010, 0, 4, w_if, w_id, w_rex(3'b110), w_rwb(3'b110, 1), '0); // 6 slt
        add_vec(6'b001000, 6'b101010, 0, 4, w_if, w_id, w_iex_add, w_iwb, '0);         // 7 addi
        add_vec(6'b001010, 6'b000000, 0, 4, w_if, w_id, w_iex_sub, w_iwb_slt, '0);     // 8 slti
        add_vec(6'b000100, 6'b000000, 1, 3, w_if, w_id, w_beq, '0, '0);                // 9 beq taken
        add_vec(6'b000100, 6'b000000, 0, 3, w_if, w_id, w_beq, '0, '0);                // 10 beq not taken
        add_vec(6'b000010, 6'b000000, 0, 3, w_if, w_id, w_j, '0, '0);                  // 11 j
        add_vec(6'b000011, 6'b000000, 0, 3, w_if, w_id, w_jal, '0, '0);                // 12 jal
        add_vec(6'b000000, 6'b001000, 0, 3, w_if, w_id, w_jr, '0, '0);                 // 13 jr

        rst     = 1'b1;
        opcode  = '0;
        funct   = '0;
        ALUzero = 1'b0;
        #3;
        check("reset decode", obs, w_if);
        @(negedge clk);
        rst = 1'b0;
        check("first IF after reset", obs, w_if);

        // Back-to-back instructions from the table
        for (int i = 0; i < nvec; i++) run_vec(i);

        // Reset asserted in the middle of LW_MEM
        opcode = 6'b100011;
        funct  = '0;
        check("lw-rst IF", obs, w_if);
        @(negedge clk);
        check("lw-rst ID", obs, w_id);
        @(negedge clk);
        check("lw-rst MEMADR", obs, w_memadr);
        @(negedge clk);
        check("lw-rst LW_MEM", obs, w_lwmem);
        #2 rst = 1'b1;
        #1 check("lw-rst async IF", obs, w_if);
        @(negedge clk);
        rst = 1'b0;
        check("lw-rst IF after release", obs, w_if);
        run_vec(1);   // sw completes normally after recovery

        // Illegal opcode: trap in ERR until reset
        opcode = 6'b111111;
        funct  = '0;
        check("ill-op IF", obs, w_if);
        @(negedge clk);
        check("ill-op ID", obs, w_id);
        @(negedge clk);
        opcode = 6'b100011;   // later opcodes must not release the trap
        for (int c = 0; c < 10; c++) begin
            check($sformatf("ill-op ERR c%0d", c), obs, w_err);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 check("ill-op rst clears", obs, w_if);
        @(negedge clk);
        rst = 1'b0;
        run_vec(13);

        // Illegal R-type funct traps from ID as well
        opcode = 6'b000000;
        funct  = 6'b111111;
        check("ill-fn IF", obs, w_if);
        @(negedge clk);
        check("ill-fn ID", obs, w_id);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("ill-fn ERR c%0d", c), obs, w_err);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 check("ill-fn rst clears", obs, w_if);
        @(negedge clk);
        rst = 1'b0;
        run_vec(12);
        check("idle IF after jal", obs, w_if);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
